// File: rtl/approx_eval_pkg.sv
// Shared types and widths for the approximate-multiplier error sweeper.
package approx_eval_pkg;
  localparam int IN_W       = 4;
  localparam int CNT_W      = 5;
  localparam int SUM_W      = 8;
  localparam int ET_DEFAULT = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/approx_err_calc.sv
// Combinational |dut_out - a*b| for a 2x2 multiplier, a = in[1:0], b = in[3:2].
module approx_err_calc
  import approx_eval_pkg::*;
(
  input  logic [IN_W-1:0] dut_in,
  input  logic [IN_W-1:0] dut_out,
  output logic [IN_W-1:0] err
);
  logic [IN_W-1:0] exact;

  assign exact = {2'b00, dut_in[1:0]} * {2'b00, dut_in[3:2]};
  assign err   = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
endmodule

// File: rtl/approx_err_sweeper.sv
// Exhaustive 16-vector error sweep of an approximate 2x2 multiplier; (2+SETTLE) cycles per vector.
// Optional err_sum accumulator compiled in with APPROX_ERR_SUM_EN.
module approx_err_sweeper
  import approx_eval_pkg::*;
#(
  parameter int ET     = ET_DEFAULT,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [IN_W-1:0]  dut_out,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  max_err,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             pass,
  output logic [SUM_W-1:0] err_sum
);
  state_t          state;
  logic [IN_W-1:0] cnt;
  logic [1:0]      settle_cnt;
  logic [IN_W-1:0] err;
  logic            accept;

  approx_err_calc u_calc (
    .dut_in  (cnt),
    .dut_out (dut_out),
    .err     (err)
  );

  assign accept = (state == IDLE) && start;
  assign dut_in = cnt;
  assign pass   = (viol_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      max_err    <= '0;
      viol_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DRIVE;
            cnt      <= '0;
            max_err  <= '0;
            viol_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        DRIVE: begin
          state      <= WAIT;
          settle_cnt <= '0;
        end
        WAIT: begin
          if (settle_cnt == 2'(SETTLE - 1)) state <= SAMPLE;
          else settle_cnt <= settle_cnt + 2'd1;
        end
        SAMPLE: begin
          if (err > max_err) max_err <= err;
          if (err > 4'(ET)) viol_cnt <= viol_cnt + 5'd1;
          // Vector 15 is terminal: the counter never wraps back to 0.
          if (cnt == 4'd15) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 4'd1;
            state <= DRIVE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APPROX_ERR_SUM_EN
  logic [SUM_W-1:0] sum_q;

  // 16 vectors x max error 15 = 240, so 8 bits never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (state == SAMPLE) begin
      sum_q <= sum_q + {4'b0000, err};
    end
  end

  assign err_sum = sum_q;
`else
  assign err_sum = '0;
`endif
endmodule

// File: tb/tb_approx_err_sweeper.sv
// Self-checking bench: table of response models with expected sweep results, plus reset and start-hold sequences.
module tb_approx_err_sweeper;
  localparam int SET     = 1;
  localparam int VEC_CYC = 2 + SET;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dut_in, dut_out, max_err;
  logic       busy, done, pass;
  logic [4:0] viol_cnt;
  logic [7:0] err_sum;

  int mode = 0;
  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  typedef struct {
    int mode;
    int mx;
    int viol;
    int sum;
    int ps;
  } vec_t;

  vec_t tbl[5];
  vec_t sb[$];

  approx_err_sweeper #(.ET(7), .SETTLE(SET)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .max_err  (max_err),
    .viol_cnt (viol_cnt),
    .pass     (pass),
    .err_sum  (err_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Response model of the multiplier under test, selected by mode.
  logic [3:0] ex_m;
  always_comb begin
    ex_m = 4'(dut_in[1:0]) * 4'(dut_in[3:2]);
    case (mode)
      0:       dut_out = ex_m;
      1:       dut_out = 4'd15;
      2:       dut_out = (dut_in == 4'd15) ? 4'd1 : ex_m;
      3:       dut_out = ex_m + 4'd1;
      default: dut_out = 4'd0;
    endcase
  end

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic int exp_sum(int s);
`ifdef APPROX_ERR_SUM_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic check_results(string nm);
    vec_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_max_err"}, int'(max_err), e.mx);
    chk({nm, "_viol_cnt"}, int'(viol_cnt), e.viol);
    chk({nm, "_pass"}, int'(pass), e.ps);
    chk({nm, "_err_sum"}, int'(err_sum), exp_sum(e.sum));
  endtask

  // Waits for done, checking dut_in sequencing and busy each cycle; k counts cycles from accept.
  task automatic follow_sweep(string nm);
    int k;
    bit seq_ok;
    k = 0;
    seq_ok = 1'b1;
    while (done !== 1'b1 && k < 200) begin
      if (dut_in !== 4'(k / VEC_CYC) || busy !== 1'b1) seq_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_latency"}, k, 16 * VEC_CYC);
    chk({nm, "_seq"}, int'(seq_ok), 1);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    check_results(nm);
  endtask

  task automatic run_sweep(input vec_t v, input string nm);
    mode = v.mode;
    sb.push_back(v);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    follow_sweep(nm);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{mode: 0, mx: 0,  viol: 0,  sum: 0,   ps: 1};
    tbl[1] = '{mode: 1, mx: 15, viol: 15, sum: 204, ps: 0};
    tbl[2] = '{mode: 2, mx: 8,  viol: 1,  sum: 8,   ps: 0};
    tbl[3] = '{mode: 3, mx: 1,  viol: 0,  sum: 16,  ps: 1};
    tbl[4] = '{mode: 4, mx: 9,  viol: 1,  sum: 36,  ps: 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dut_in", int'(dut_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 1);
    chk("rst_err_sum", int'(err_sum), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_sweep(tbl[i], $sformatf("sweep%0d", i));

    // Reset in the middle of a sweep: outputs return immediately, then a clean sweep follows.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_dut_in", int'(dut_in), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_max_err", int'(max_err), 0);
    chk("midrst_viol_cnt", int'(viol_cnt), 0);
    chk("midrst_err_sum", int'(err_sum), 0);
    chk("midrst_pass", int'(pass), 1);
    @(negedge clk); rst_n = 1'b1;
    run_sweep(tbl[0], "post_rst");

    // Start held through the whole sweep and the done cycle: one sweep, one done pulse.
    v = tbl[2];
    mode = v.mode;
    sb.push_back(v);
    @(negedge clk); done_cnt = 0; start = 1'b1;
    @(posedge clk); #1;
    follow_sweep("held");
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_busy_after", int'(busy), 0);
    chk("held_done_cnt", done_cnt, 1);
    chk("held_max_err_kept", int'(max_err), 8);
    chk("held_viol_kept", int'(viol_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
